// File: rtl/mux2_rr_feeder.sv
// rtl/mux2_rr_feeder.sv - two-source round-robin feeder for the 2:1 mux datapath, registered output slot
// Optional ARB_BURST_EN: on ties the current winner keeps the grant for up to MAX_BURST words.
module mux2_rr_feeder #(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b,
  output logic             b_ready,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  localparam bit BURST_CFG_OK = (MAX_BURST >= 1) && (MAX_BURST <= 255);

  slot_state_t state_q;
  slot_state_t state_d;

  logic slot_free;
  logic grant_a;
  logic grant_b;
  logic grant;
  logic pick_b;
  // 1 = B was granted last, so the first tie after reset goes to A
  logic last_q;

  assign y_valid   = (state_q == FULL);
  assign slot_free = !y_valid || y_ready;
  assign grant     = grant_a || grant_b;
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;

`ifdef ARB_BURST_EN
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  logic [7:0] burst_q;
  logic [7:0] burst_d;
  logic       keep_winner;

  // A zero count means no burst is in progress, so the pointer alone decides
  assign keep_winner = (burst_q != 8'd0) && (burst_q < BURST_LIMIT);
  assign pick_b      = keep_winner ? last_q : !last_q;

  always_comb begin
    burst_d = burst_q;
    if (grant) begin
      if ((grant_b == last_q) && (burst_q != 8'd0)) begin
        if (burst_q != 8'hff) begin
          burst_d = burst_q + 8'd1;
        end
      end else begin
        burst_d = 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q <= 8'd0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign pick_b = !last_q;
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (slot_free) begin
      if (a_valid && !b_valid) begin
        grant_a = 1'b1;
      end else if (b_valid && !a_valid) begin
        grant_b = 1'b1;
      end else if (a_valid && b_valid) begin
        if (pick_b) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (grant) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (y_ready && !grant) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // y and s only move on a grant; an emptied slot keeps its last word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y      <= '0;
      s      <= 1'b0;
      last_q <= 1'b1;
    end else if (grant) begin
      y      <= grant_b ? b : a;
      s      <= grant_b;
      last_q <= grant_b;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(a_ready && b_ready));
  assert property (@(posedge clk) disable iff (!rst_n) (a_ready |-> a_valid) and (b_ready |-> b_valid));
  assert property (@(posedge clk) BURST_CFG_OK);

endmodule
